// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: selects the next fetch address from
// sequential, branch, exception and ERET sources and registers it as pc.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_exc,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        adel,
  output logic        redirect
);

  logic [31:0] r_pc;
  logic        r_pcValid;
  logic        r_adel;
  logic        r_brPend;
  logic [31:0] r_brPendTgt;

  logic [31:0] w_fetchAddr;
  logic [31:0] w_seqAddr;
  logic        w_exceptional;

  assign w_seqAddr     = r_pc + 32'd4;
  assign w_exceptional = flush_exc | eret;

  // Exception and ERET outrank stall; a held branch only fires once unstalled.
  always_comb begin
    w_fetchAddr = w_seqAddr;
    if (flush_exc)
      w_fetchAddr = EXC_VECTOR;
    else if (eret)
      w_fetchAddr = epc;
    else if (stall)
      w_fetchAddr = r_pc;
    else if (br_taken)
      w_fetchAddr = br_target;
    else if (r_brPend)
      w_fetchAddr = r_brPendTgt;
  end

  // pc resets one word below the reset vector so the first fetch lands on it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_VECTOR - 32'd4;
      r_pcValid <= 1'b0;
      r_adel    <= 1'b0;
    end else begin
      r_pc      <= w_fetchAddr;
      r_pcValid <= 1'b1;
      r_adel    <= (w_fetchAddr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_brPend    <= 1'b0;
      r_brPendTgt <= 32'd0;
    end else if (w_exceptional || !stall) begin
      r_brPend <= 1'b0;
    end else if (br_taken) begin
      r_brPend    <= 1'b1;
      r_brPendTgt <= br_target;
    end
  end

  assign fetch_addr = w_fetchAddr;
  assign pc         = r_pc;
  assign pc_valid   = r_pcValid;
  assign adel       = r_adel;
  assign redirect   = w_exceptional | (!stall & (br_taken | r_brPend));

endmodule
